// File: rtl/mips_exec_mem_unit.sv
// Single-cycle MIPS execute/memory slice: decoder, ALU, word-addressed data
// memory and write-back select. Only memory writes (and the memory clear) are clocked.
module mips_exec_mem_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [15:0] immediate,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        jump,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] mem_read_data,
  output logic [31:0] write_back_data
);

  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_NOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  logic                 zext;
  logic        [31:0]   op_b;
  logic signed [31:0]   a_s;
  logic signed [31:0]   b_s;
  logic        [AW-1:0] idx;
  logic        [31:0]   mem_q [MEM_WORDS];

  always_comb begin
    reg_dst     = 1'b0;
    alu_src     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    alu_control = ALU_ADD;
    case (opcode)
      6'h00: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        case (funct)
          6'h20, 6'h21: alu_control = ALU_ADD;
          6'h22, 6'h23: alu_control = ALU_SUB;
          6'h24:        alu_control = ALU_AND;
          6'h25:        alu_control = ALU_OR;
          6'h26:        alu_control = ALU_XOR;
          6'h27:        alu_control = ALU_NOR;
          6'h2A:        alu_control = ALU_SLT;
          6'h2B:        alu_control = ALU_SLTU;
          6'h00:        alu_control = ALU_SLL;
          6'h02:        alu_control = ALU_SRL;
          6'h03:        alu_control = ALU_SRA;
          default: begin
            reg_dst   = 1'b0;
            reg_write = 1'b0;
          end
        endcase
      end
      6'h08, 6'h09: begin alu_src = 1'b1; reg_write = 1'b1; end
      6'h0A: begin alu_control = ALU_SLT; alu_src = 1'b1; reg_write = 1'b1; end
      6'h0C: begin alu_control = ALU_AND; alu_src = 1'b1; reg_write = 1'b1; end
      6'h0D: begin alu_control = ALU_OR;  alu_src = 1'b1; reg_write = 1'b1; end
      6'h0E: begin alu_control = ALU_XOR; alu_src = 1'b1; reg_write = 1'b1; end
      6'h0F: begin alu_control = ALU_LUI; alu_src = 1'b1; reg_write = 1'b1; end
      6'h23: begin
        alu_src    = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      6'h2B: begin alu_src = 1'b1; mem_write = 1'b1; end
      6'h04, 6'h05: begin alu_control = ALU_SUB; branch = 1'b1; end
      6'h02: jump = 1'b1;
      default: ;
    endcase
  end

  // Logical immediates are zero-extended; everything else sign-extends.
  assign zext = (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E);
  assign op_b = !alu_src ? rt_data
              : zext     ? {16'h0000, immediate}
                         : {{16{immediate[15]}}, immediate};
  assign a_s  = rs_data;
  assign b_s  = op_b;

  always_comb begin
    alu_result = 32'd0;
    case (alu_control)
      ALU_AND:  alu_result = rs_data & op_b;
      ALU_OR:   alu_result = rs_data | op_b;
      ALU_ADD:  alu_result = rs_data + op_b;
      ALU_XOR:  alu_result = rs_data ^ op_b;
      ALU_NOR:  alu_result = ~(rs_data | op_b);
      ALU_SLL:  alu_result = op_b << shamt;
      ALU_SUB:  alu_result = rs_data - op_b;
      ALU_SLT:  alu_result = {31'd0, a_s < b_s};
      ALU_SRL:  alu_result = op_b >> shamt;
      ALU_SRA:  alu_result = b_s >>> shamt;
      ALU_SLTU: alu_result = {31'd0, rs_data < op_b};
      ALU_LUI:  alu_result = {immediate, 16'h0000};
      default:  alu_result = 32'd0;
    endcase
  end

  assign zero = (alu_result == 32'd0);

  // Byte address wraps modulo the memory size; low two bits are ignored.
  assign idx             = alu_result[AW+1:2];
  assign mem_read_data   = mem_read ? mem_q[idx] : 32'd0;
  assign write_back_data = mem_to_reg ? mem_read_data : alu_result;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= 32'd0;
    end else if (mem_write) begin
      mem_q[idx] <= rt_data;
    end
  end

endmodule

// File: tb/tb_mips_exec_mem_unit.sv
// Directed-vector bench for mips_exec_mem_unit: a driver queues the expected
// response of each vector and a negedge monitor pops and compares it.
module tb_mips_exec_mem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] immediate;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        reg_dst, alu_src, mem_to_reg, reg_write;
  logic        mem_read, mem_write, branch, jump;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] mem_read_data;
  logic [31:0] write_back_data;

  mips_exec_mem_unit #(.MEM_WORDS(256)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .shamt(shamt),
    .immediate(immediate), .rs_data(rs_data), .rt_data(rt_data),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .alu_control(alu_control),
    .alu_result(alu_result), .zero(zero), .mem_read_data(mem_read_data),
    .write_back_data(write_back_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [7:0]  flags;
    logic [3:0]  ctl;
    logic [31:0] res;
    logic        z;
    logic [31:0] mrd;
    logic [31:0] wb;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vid      = 0;
  logic rst_v    = 1'b0;

  // Flag byte order: reg_dst alu_src mem_to_reg reg_write mem_read mem_write branch jump
  localparam logic [7:0] F_R  = 8'h90;
  localparam logic [7:0] F_I  = 8'h50;
  localparam logic [7:0] F_LW = 8'h78;
  localparam logic [7:0] F_SW = 8'h44;
  localparam logic [7:0] F_BR = 8'h02;
  localparam logic [7:0] F_J  = 8'h01;
  localparam logic [7:0] F_0  = 8'h00;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL v%0d.%s actual=%h required=%h", id, nm, act, req);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [7:0] fl, input logic [3:0] ctl, input logic [31:0] res,
                       input logic [31:0] mrd, input logic [31:0] wb);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_v; opcode = op; funct = fn; shamt = sh; immediate = imm;
    rs_data = rs; rt_data = rt;
    e.id = vid; e.flags = fl; e.ctl = ctl; e.res = res; e.z = (res == 32'd0);
    e.mrd = mrd; e.wb = wb;
    exp_q.push_back(e);
    vid++;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("flags", e.id, {24'd0, reg_dst, alu_src, mem_to_reg, reg_write,
                          mem_read, mem_write, branch, jump}, {24'd0, e.flags});
      chk("alu_control", e.id, {28'd0, alu_control}, {28'd0, e.ctl});
      chk("alu_result", e.id, alu_result, e.res);
      chk("zero", e.id, {31'd0, zero}, {31'd0, e.z});
      chk("mem_read_data", e.id, mem_read_data, e.mrd);
      chk("write_back_data", e.id, write_back_data, e.wb);
    end
  end

  initial begin
    reset = 1'b0; opcode = '0; funct = '0; shamt = '0; immediate = '0;
    rs_data = '0; rt_data = '0;
    // Reset held low: combinational path still live, memory reads zero
    rst_v = 1'b0;
    issue(6'h23, 6'h00, 5'd0, 16'h0000, 32'h10, 32'h0, F_LW, 4'd2, 32'h10, 32'h0, 32'h0);
    issue(6'h08, 6'h00, 5'd0, 16'h0003, 32'h1, 32'h0, F_I, 4'd2, 32'h4, 32'h0, 32'h4);
    rst_v = 1'b1;
    // ALU / decode vectors
    issue(6'h08, 6'h00, 5'd0, 16'h0005, 32'h0, 32'h0, F_I, 4'd2, 32'h5, 32'h0, 32'h5);
    issue(6'h00, 6'h20, 5'd0, 16'h0000, 32'h3, 32'h5, F_R, 4'd2, 32'h8, 32'h0, 32'h8);
    issue(6'h00, 6'h22, 5'd0, 16'h0000, 32'h3, 32'h5, F_R, 4'd6, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFE);
    issue(6'h00, 6'h2A, 5'd0, 16'h0000, 32'h3, 32'h5, F_R, 4'd7, 32'h1, 32'h0, 32'h1);
    issue(6'h04, 6'h00, 5'd0, 16'h0000, 32'h7, 32'h7, F_BR, 4'd6, 32'h0, 32'h0, 32'h0);
    issue(6'h05, 6'h00, 5'd0, 16'h0000, 32'h7, 32'h3, F_BR, 4'd6, 32'h4, 32'h0, 32'h4);
    issue(6'h0C, 6'h00, 5'd0, 16'hFFFF, 32'hFFFFFFFF, 32'h0, F_I, 4'd0, 32'h0000FFFF, 32'h0, 32'h0000FFFF);
    issue(6'h08, 6'h00, 5'd0, 16'hFFFF, 32'h1, 32'h0, F_I, 4'd2, 32'h0, 32'h0, 32'h0);
    issue(6'h0F, 6'h00, 5'd0, 16'h1234, 32'h5, 32'h0, F_I, 4'd11, 32'h12340000, 32'h0, 32'h12340000);
    issue(6'h00, 6'h03, 5'd4, 16'h0000, 32'h1, 32'h80000000, F_R, 4'd9, 32'hF8000000, 32'h0, 32'hF8000000);
    issue(6'h00, 6'h02, 5'd4, 16'h0000, 32'h1, 32'h80000000, F_R, 4'd8, 32'h08000000, 32'h0, 32'h08000000);
    issue(6'h00, 6'h00, 5'd1, 16'h0000, 32'h0, 32'h3, F_R, 4'd5, 32'h6, 32'h0, 32'h6);
    issue(6'h00, 6'h2B, 5'd0, 16'h0000, 32'h1, 32'hFFFFFFFF, F_R, 4'd10, 32'h1, 32'h0, 32'h1);
    issue(6'h00, 6'h2A, 5'd0, 16'h0000, 32'h1, 32'hFFFFFFFF, F_R, 4'd7, 32'h0, 32'h0, 32'h0);
    issue(6'h00, 6'h27, 5'd0, 16'h0000, 32'h0, 32'h0F0F0F0F, F_R, 4'd4, 32'hF0F0F0F0, 32'h0, 32'hF0F0F0F0);
    issue(6'h0E, 6'h00, 5'd0, 16'h00FF, 32'h00000F0F, 32'h0, F_I, 4'd3, 32'h00000FF0, 32'h0, 32'h00000FF0);
    issue(6'h0D, 6'h00, 5'd0, 16'h8000, 32'h1, 32'h0, F_I, 4'd1, 32'h00008001, 32'h0, 32'h00008001);
    issue(6'h0A, 6'h00, 5'd0, 16'hFFFF, 32'hFFFFFFFE, 32'h0, F_I, 4'd7, 32'h1, 32'h0, 32'h1);
    issue(6'h02, 6'h00, 5'd0, 16'h0000, 32'h5, 32'h6, F_J, 4'd2, 32'hB, 32'h0, 32'hB);
    issue(6'h3F, 6'h00, 5'd0, 16'h0000, 32'h1, 32'h2, F_0, 4'd2, 32'h3, 32'h0, 32'h3);
    issue(6'h00, 6'h3F, 5'd0, 16'h0000, 32'h1, 32'h2, F_0, 4'd2, 32'h3, 32'h0, 32'h3);
    // Store then load, address wrap, unaligned and negative offsets
    issue(6'h2B, 6'h00, 5'd0, 16'h0000, 32'h0, 32'd15, F_SW, 4'd2, 32'h0, 32'h0, 32'h0);
    issue(6'h23, 6'h00, 5'd0, 16'h0000, 32'h0, 32'h0, F_LW, 4'd2, 32'h0, 32'd15, 32'd15);
    issue(6'h2B, 6'h00, 5'd0, 16'h0000, 32'd1028, 32'h55, F_SW, 4'd2, 32'h404, 32'h0, 32'h404);
    issue(6'h23, 6'h00, 5'd0, 16'h0000, 32'h4, 32'h0, F_LW, 4'd2, 32'h4, 32'h55, 32'h55);
    issue(6'h23, 6'h00, 5'd0, 16'h0006, 32'h0, 32'h0, F_LW, 4'd2, 32'h6, 32'h55, 32'h55);
    issue(6'h23, 6'h00, 5'd0, 16'hFFFC, 32'h8, 32'h0, F_LW, 4'd2, 32'h4, 32'h55, 32'h55);
    // Reset mid-operation suppresses the write and clears memory
    issue(6'h2B, 6'h00, 5'd0, 16'h0000, 32'h8, 32'd42, F_SW, 4'd2, 32'h8, 32'h0, 32'h8);
    issue(6'h23, 6'h00, 5'd0, 16'h0000, 32'h8, 32'h0, F_LW, 4'd2, 32'h8, 32'd42, 32'd42);
    rst_v = 1'b0;
    issue(6'h2B, 6'h00, 5'd0, 16'h0000, 32'h8, 32'd99, F_SW, 4'd2, 32'h8, 32'h0, 32'h8);
    rst_v = 1'b1;
    issue(6'h23, 6'h00, 5'd0, 16'h0000, 32'h8, 32'h0, F_LW, 4'd2, 32'h8, 32'h0, 32'h0);
    issue(6'h23, 6'h00, 5'd0, 16'h0000, 32'h4, 32'h0, F_LW, 4'd2, 32'h4, 32'h0, 32'h0);
    issue(6'h23, 6'h00, 5'd0, 16'h0000, 32'h0, 32'h0, F_LW, 4'd2, 32'h0, 32'h0, 32'h0);
    repeat (5) @(posedge clk);
    chk("scoreboard_drained", -1, exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_exec_mem_unit.md
MIPS_EXEC_MEM_UNIT -- requirements
Module: mips_exec_mem_unit

Interface
REQ-001 Parameter MEM_WORDS, default 256, number of 32-bit data-memory words (power of two).
REQ-002 Ports, in this order:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- opcode  input  6  instruction [31:26].
- funct  input  6  instruction [5:0].
- shamt  input  5  shift amount.
- immediate  input  16  instruction [15:0].
- rs_data  input  32  ALU operand A.
- rt_data  input  32  operand B / store data.
- reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump  output  1 each  control flags.
- alu_control  output  4  ALU operation code.
- alu_result  output  32  ALU result, also the memory byte address.
- zero  output  1  high when alu_result == 0.
- mem_read_data  output  32  data-memory read value.
- write_back_data  output  32  register write-back value.

Function
REQ-003 The controller, ALU, data-memory read path and write-back mux SHALL be combinational; only data-memory writes are clocked.
REQ-004 alu_control codes SHALL be:
- 0 AND; 1 OR; 2 ADD; 3 XOR; 4 NOR; 5 SLL; 6 SUB; 7 SLT (signed); 8 SRL; 9 SRA; 10 SLTU; 11 LUI (imm<<16).
- 12-15 produce 0.
REQ-005 R-type (opcode 0x00) SHALL assert reg_dst=1, reg_write=1 and clear all other flags. funct decoding:
- 0x20/0x21 ADD; 0x22/0x23 SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR.
- 0x2A SLT; 0x2B SLTU; 0x00 SLL; 0x02 SRL; 0x03 SRA.
- Any other funct: all flags 0, alu_control=ADD.
REQ-006 I-type opcodes SHALL decode as follows. All flags not listed are 0.
- 0x08/0x09 addi/addiu: ADD, alu_src=1, reg_write=1.
- 0x0A slti: SLT, alu_src=1, reg_write=1.
- 0x0C andi: AND, alu_src=1, reg_write=1.
- 0x0D ori: OR, alu_src=1, reg_write=1.
- 0x0E xori: XOR, alu_src=1, reg_write=1.
- 0x0F lui: LUI, alu_src=1, reg_write=1.
- 0x23 lw: ADD, alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1.
- 0x2B sw: ADD, alu_src=1, mem_write=1.
- 0x04 beq / 0x05 bne: SUB, branch=1.
REQ-007 Jump and unknown opcodes:
- 0x02 j: jump=1, alu_control=ADD, all other flags 0.
- Any other opcode: all flags 0, alu_control=ADD.
REQ-008 Operand B SHALL be selected as follows:
- alu_src=0: rt_data.
- alu_src=1 with andi/ori/xori: zero-extended immediate.
- alu_src=1, all other opcodes: sign-extended immediate.
REQ-009 Arithmetic rules:
- ADD/SUB are modulo 2^32; overflow is ignored.
- SLT/SLTU produce 32'd1 or 32'd0.
- Shifts use shamt and shift operand B (rt_data).
REQ-010 zero SHALL equal (alu_result == 0) for every operation.
REQ-011 Memory addressing: word index = alu_result[log2(MEM_WORDS)+1 : 2]. Address bits [1:0] and bits above the index are ignored, so addresses wrap modulo 4*MEM_WORDS.
REQ-012 Memory read: mem_read_data SHALL be mem[index] when mem_read=1, else 32'd0.
REQ-013 Memory write: on the rising clk edge with reset=1 and mem_write=1, mem[index] SHALL be loaded with rt_data.
REQ-014 A read of the same address in the cycle of a write SHALL return the old value; the new value is visible after the edge.
REQ-015 write_back_data SHALL be mem_read_data when mem_to_reg=1, else alu_result.

Reset
REQ-016 On a rising clk edge with reset=0, every memory word SHALL clear to 0, and any simultaneous write SHALL be suppressed.
REQ-017 Combinational outputs SHALL follow their inputs regardless of reset; after reset every mem_read_data value is 0.

Verification
REQ-018 The bench SHALL cover the following scenarios:
- addi: opcode 0x08, rs_data=0, imm=5 -> alu_result=5, reg_write=1, alu_src=1, reg_dst=0, write_back_data=5.
- R-type add then sub: rs_data=3, rt_data=5. add (funct 0x20) -> 8, reg_dst=1. sub (funct 0x22) -> 0xFFFFFFFE, zero=0. slt (funct 0x2A) -> 1.
- sw then lw: sw with rs_data=0, imm=0, rt_data=15, one clock edge. Then lw at the same address -> mem_read_data=15, write_back_data=15, mem_to_reg=1.
- beq: rs_data=rt_data=7 -> zero=1, branch=1, reg_write=0.
- andi with imm=0xFFFF, rs_data=0xFFFFFFFF -> alu_result=0x0000FFFF (zero-extended). addi with imm=0xFFFF, rs_data=1 -> alu_result=0.
- Reset mid-operation: store 42 at address 8, then hold reset=0 for one edge with mem_write=1 and rt_data=99. Release reset and lw address 8 -> 0.
